uart_tx_fifo: RTL and testbench

//  Consumer end of the store-to-UART path. Accepts byte writes (uart/uart_we) issued
//  by the memory-access stage, buffers them in a FIFO and serialises each byte onto a

---
 rtl/uart_tx_fifo.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Takes byte writes from the memory-access stage, buffers them in a FIFO and
//   sends each byte on a single TX line as an 8N1 frame, LSB first. Writers are
//   never stalled. A write that finds the FIFO full is dropped and sets a sticky
//   overflow flag.
//
// Parameters
//   CLK_FREQ    core clock in Hz
//   BAUD_RATE   line rate; BIT_CYCLES = CLK_FREQ / BAUD_RATE, must be >= 2
//   FIFO_DEPTH  byte entries; power of two, >= 2
//
// Ports
//   clk       in   core clock, rising edge
//   rst       in   asynchronous, active-high reset
//   uart      in   byte to transmit, sampled when uart_we = 1
//   uart_we   in   push request, one byte per cycle
//   ovf_clr   in   clears the overflow flag; a drop in the same cycle wins
//   txd       out  registered serial line, idle high
//   busy      out  a frame is on the line or the FIFO is non-empty
//   full      out  FIFO holds FIFO_DEPTH entries
//   level     out  FIFO occupancy, 0..FIFO_DEPTH
//   overflow  out  sticky: at least one push was dropped
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    uart,
    input  logic                          uart_we,
    input  logic                          ovf_clr,
    output logic                          txd,
    output logic                          busy,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int LW         = AW + 1;
    localparam int CW         = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;

    generate
        if (BIT_CYCLES < 2 || FIFO_DEPTH < 2 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
            $fatal(1, "uart_tx_fifo: BIT_CYCLES must be >= 2 and FIFO_DEPTH a power of two >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // FIFO storage and pointers; the extra pointer bit tells full from empty.
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic [LW-1:0] w_level;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          r_ovf;

    // Transmitter state
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_bcnt;
    logic [CW-1:0] w_bcnt_nxt;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic          r_txd;
    logic          w_txd_nxt;
    logic          w_bit_end;

    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_level == LW'(FIFO_DEPTH));
    assign w_empty   = (w_level == '0);
    // A full FIFO still takes a byte when the transmitter pops in the same cycle.
    assign w_push    = uart_we && (!w_full || w_pop);
    assign w_bit_end = (r_bcnt == CW'(BIT_CYCLES - 1));

    // FIFO pointers and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (uart_we && !w_push) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Storage needs no reset; stale entries are never read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= uart;
        end
    end

    // Transmitter state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_bcnt  <= '0;
            r_bit   <= '0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_bit   <= w_bit_nxt;
            r_txd   <= w_txd_nxt;
        end
    end

    always_ff @(posedge clk) begin
        r_shift <= w_shift_nxt;
    end

    // Next-state logic. w_txd_nxt is the line level for the cycle after the
    // edge, so txd changes exactly on bit boundaries.
    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_txd_nxt   = r_txd;
        w_pop       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_txd_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rd_ptr[AW-1:0]];
                    w_state_nxt = S_START;
                    w_bcnt_nxt  = '0;
                    w_txd_nxt   = 1'b0;
                end
            end

            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_bcnt_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_txd_nxt   = r_shift[0];
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                end else begin
                    w_bcnt_nxt = r_bcnt + CW'(1);
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    w_bcnt_nxt = '0;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_txd_nxt   = 1'b1;
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_txd_nxt   = r_shift[0];
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                    end
                end else begin
                    w_bcnt_nxt = r_bcnt + CW'(1);
                end
            end

            S_STOP: begin
                if (w_bit_end) begin
                    w_bcnt_nxt = '0;
                    // Chain straight into the next start bit when data waits.
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = r_mem[r_rd_ptr[AW-1:0]];
                        w_state_nxt = S_START;
                        w_txd_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_txd_nxt   = 1'b1;
                    end
                end else begin
                    w_bcnt_nxt = r_bcnt + CW'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_bcnt_nxt  = '0;
                w_txd_nxt   = 1'b1;
            end
        endcase
    end

    assign txd      = r_txd;
    assign busy     = (r_state != S_IDLE) || !w_empty;
    assign full     = w_full;
    assign level    = w_level;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo with BIT_CYCLES = 10 and FIFO_DEPTH = 16.
// The reference model describes the line in terms of frames. A new frame may
// start at an edge when a byte was already buffered and at least one frame time
// has passed since the previous start. The line level is a function of the
// offset into the current frame. Accepted bytes are also queued for a UART
// receiver process that decodes txd and checks the byte order.
module tb_uart_tx_fifo;

    localparam int CLK_FREQ  = 10;
    localparam int BAUD_RATE = 1;
    localparam int DEPTH     = 16;
    localparam int BC        = 10;
    localparam int FRAME     = 10 * BC;

    logic       clk;
    logic       rst;
    logic [7:0] uart;
    logic       uart_we;
    logic       ovf_clr;
    logic       txd;
    logic       busy;
    logic       full;
    logic [4:0] level;
    logic       overflow;

    uart_tx_fifo #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .uart     (uart),
        .uart_we  (uart_we),
        .ovf_clr  (ovf_clr),
        .txd      (txd),
        .busy     (busy),
        .full     (full),
        .level    (level),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0]  mq[$];        // bytes waiting in the FIFO
    logic [7:0]  sb[$];        // accepted bytes not yet decoded from the line
    int unsigned ecount  = 0;  // clock edges since start (outside reset)
    int unsigned fstart  = 0;  // edge at which the current frame began
    bit          started = 0;
    logic [7:0]  cur     = 8'h00;
    bit          m_ovf   = 0;
    int          epoch   = 0;
    bit          m_pop;
    bit          m_acc;
    bit          e_txd   = 1;
    bit          e_busy  = 0;

    task automatic update_exp();
        int unsigned off;
        int          k;
        off    = ecount - fstart;
        e_txd  = 1'b1;
        e_busy = (mq.size() != 0);
        if (started && off < FRAME) begin
            k      = int'(off / BC);
            e_busy = 1'b1;
            if (k == 0)      e_txd = 1'b0;
            else if (k <= 8) e_txd = cur[k-1];
        end
    endtask

    initial begin
        update_exp();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                sb.delete();
                started = 0;
                m_ovf   = 0;
                epoch++;
            end else begin
                ecount++;
                m_pop = (mq.size() != 0) && (!started || (ecount - fstart) >= FRAME);
                m_acc = uart_we && ((mq.size() < DEPTH) || m_pop);
                if (m_pop) begin
                    cur     = mq.pop_front();
                    fstart  = ecount;
                    started = 1;
                end
                if (m_acc) begin
                    mq.push_back(uart);
                    sb.push_back(uart);
                end
                if (uart_we && !m_acc) m_ovf = 1;
                else if (ovf_clr)      m_ovf = 0;
            end
            update_exp();
        end
    end

    // Cycle-level comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            chk("txd",      txd,      e_txd);
            chk("busy",     busy,     e_busy);
            chk("level",    level,    mq.size());
            chk("full",     full,     mq.size() == DEPTH);
            chk("overflow", overflow, m_ovf);
        end
    end

    // UART receiver: sample mid-bit, compare each decoded byte with the scoreboard
    initial begin
        logic [7:0] rx;
        int         ep;
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin
                ep = epoch;
                repeat (BC / 2) @(negedge clk);
                for (int j = 0; j < 8; j++) begin
                    repeat (BC) @(negedge clk);
                    rx[j] = txd;
                end
                repeat (BC) @(negedge clk);
                if (ep == epoch && !rst) begin
                    chk("rx_stop",  txd, 1);
                    chk("rx_avail", sb.size() != 0, 1);
                    if (sb.size() != 0) chk("rx_byte", rx, sb.pop_front());
                end
            end
        end
    end

    task automatic drive(input bit we, input logic [7:0] d, input bit clr);
        uart_we = we;
        uart    = d;
        ovf_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        rst     = 1'b1;
        uart    = 8'h00;
        uart_we = 1'b0;
        ovf_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_txd",   txd,      1);
        chk("rst_busy",  busy,     0);
        chk("rst_level", level,    0);
        chk("rst_full",  full,     0);
        chk("rst_ovf",   overflow, 0);

        // Single byte 0x55: start bit follows the push by one edge
        drive(1'b1, 8'h55, 1'b0);
        chk("t1_level_e0", level, 1);
        drive(1'b0, 8'h00, 1'b0);
        chk("t1_txd_e1",   txd,   0);
        chk("t1_level_e1", level, 0);
        idle(99);
        chk("t1_busy_e100", busy, 1);
        idle(1);
        chk("t1_busy_e101", busy, 0);

        // Back-to-back frames
        drive(1'b1, 8'h41, 1'b0);
        drive(1'b1, 8'h42, 1'b0);
        drive(1'b1, 8'h43, 1'b0);
        idle(310);

        // 18 pushes from idle: 17 accepted, last one dropped
        for (int i = 0; i < 18; i++) drive(1'b1, 8'($urandom), 1'b0);
        chk("t3_full",  full,     1);
        chk("t3_level", level,    16);
        chk("t3_ovf",   overflow, 1);
        drive(1'b0, 8'h00, 1'b1);
        chk("t3_ovf_clr", overflow, 0);

        // Push into a full FIFO on the edge where the next frame pops
        for (int i = 0; i < 200 && !(started && (ecount + 1 - fstart) >= FRAME); i++)
            drive(1'b0, 8'h00, 1'b0);
        chk("t4_full_before", full, 1);
        drive(1'b1, 8'hA5, 1'b0);
        chk("t4_level", level,    16);
        chk("t4_full",  full,     1);
        chk("t4_ovf",   overflow, 0);
        idle(17 * FRAME + 50);

        // Reset in the middle of a data bit with five bytes queued
        for (int i = 0; i < 6; i++) drive(1'b1, 8'($urandom), 1'b0);
        idle(40);
        chk("t5_level_before", level, 5);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_txd",   txd,   1);
        chk("t5_level", level, 0);
        chk("t5_busy",  busy,  0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(150);

        // Drop while clearing: the drop wins; a lone clear then clears
        for (int i = 0; i < 17; i++) drive(1'b1, 8'($urandom), 1'b0);
        chk("t6_full", full, 1);
        drive(1'b1, 8'hEE, 1'b1);
        chk("t6_ovf_set", overflow, 1);
        chk("t6_level",   level,    16);
        drive(1'b0, 8'h00, 1'b1);
        chk("t6_ovf_clr", overflow, 0);
        idle(17 * FRAME + 50);

        // Random traffic with occasional bursts and clears
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                for (int b = 0; b < 20; b++) drive(1'b1, 8'($urandom), 1'b0);
            end else begin
                drive($urandom_range(0, 19) == 0, 8'($urandom), $urandom_range(0, 49) == 0);
            end
        end
        idle(17 * FRAME + 200);

        chk("end_sb_empty", sb.size(), 0);
        chk("end_busy",     busy,      0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
